// File: rtl/io_console_ctrl_pkg.sv
// Shared constants, state types and helper functions for the console I/O controller.
`timescale 1ns/1ps
package io_console_pkg;

    // Seven-segment images, gfedcba, active-low
    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_MINUS = 7'h3F;
    localparam logic [6:0] SEG_E     = 7'h06;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    typedef enum logic [1:0] {IN_IDLE, IN_WAIT, IN_DONE} in_state_t;
    typedef enum logic [1:0] {CV_IDLE, CV_SHIFT, CV_DONE} cv_state_t;

    function automatic longint unsigned pow10(input int n);
        longint unsigned p;
        p = 64'd1;
        for (int i = 0; i < n; i++) p = p * 64'd10;
        return p;
    endfunction

    // Decimal digits of 2^dw (floor(dw*log10(2))+1), four bits each
    function automatic int bcd_width(input int dw);
        return 4 * ((dw * 30103) / 100000 + 1);
    endfunction

    function automatic logic [6:0] seg_of(input logic [3:0] d);
        case (d)
            4'd0:    return SEG_0;
            4'd1:    return SEG_1;
            4'd2:    return SEG_2;
            4'd3:    return SEG_3;
            4'd4:    return SEG_4;
            4'd5:    return SEG_5;
            4'd6:    return SEG_6;
            4'd7:    return SEG_7;
            4'd8:    return SEG_8;
            4'd9:    return SEG_9;
            default: return SEG_BLANK;
        endcase
    endfunction

endpackage

// File: rtl/io_console_ctrl_if.sv
// Processor-side bundle of the console controller: IN/OUT handshake, switches, button, display.
`timescale 1ns/1ps
interface io_console_ctrl_if #(
    parameter int DATA_W     = 32,
    parameter int SW_W       = 15,
    parameter int NUM_DIGITS = 8
);
    logic                    cpu_step;
    logic                    in_req;
    logic                    out_req;
    logic                    halt;
    logic [DATA_W-1:0]       cpu_data;
    logic [SW_W-1:0]         SW;
    logic                    insert;
    logic [DATA_W-1:0]       user_input;
    logic                    stall;
    logic                    in_ack;
    logic                    busy;
    logic [7*NUM_DIGITS-1:0] HEX;

    modport master (
        output cpu_step, in_req, out_req, halt, cpu_data, SW, insert,
        input  user_input, stall, in_ack, busy, HEX
    );

    modport slave (
        input  cpu_step, in_req, out_req, halt, cpu_data, SW, insert,
        output user_input, stall, in_ack, busy, HEX
    );
endinterface

// File: rtl/io_console_ctrl_bin2bcd_seq.sv
// Sequential double-dabble: one binary bit per cycle, DATA_W cycles per conversion.
`timescale 1ns/1ps
module bin2bcd_seq #(
    parameter int DATA_W = 32,
    parameter int BCD_W  = 40
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_start,
    input  logic [DATA_W-1:0] i_bin,
    output logic              o_busy,
    output logic              o_done,
    output logic [BCD_W-1:0]  o_bcd
);
    localparam int CNT_W = $clog2(DATA_W + 1);

    logic [CNT_W-1:0]  r_cnt;
    logic              r_busy;
    logic [DATA_W-1:0] r_bin;
    logic [BCD_W-1:0]  r_bcd;
    logic [BCD_W-1:0]  w_adj;

    always_comb begin
        w_adj = r_bcd;
        for (int d = 0; d < BCD_W / 4; d++)
            if (r_bcd[4*d +: 4] >= 4'd5) w_adj[4*d +: 4] = r_bcd[4*d +: 4] + 4'd3;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy <= 1'b0;
            r_cnt  <= '0;
        end else if (i_start) begin
            r_busy <= 1'b1;
            r_cnt  <= CNT_W'(DATA_W);
        end else if (r_busy) begin
            r_cnt <= r_cnt - CNT_W'(1);
            if (r_cnt == CNT_W'(1)) r_busy <= 1'b0;
        end
    end

    // Datapath carries no reset; it is always loaded by i_start before use
    always_ff @(posedge clk) begin
        if (i_start) begin
            r_bin <= i_bin;
            r_bcd <= '0;
        end else if (r_busy) begin
            r_bin <= r_bin << 1;
            r_bcd <= BCD_W'({w_adj, r_bin[DATA_W-1]});
        end
    end

    assign o_busy = r_busy;
    assign o_done = r_busy & (r_cnt == CNT_W'(1));
    assign o_bcd  = r_bcd;
endmodule

// File: rtl/io_console_ctrl.sv
// Console I/O controller: stalling IN with synchronised insert button, buffered OUT to a decimal display.
`timescale 1ns/1ps
module io_console_ctrl
    import io_console_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int SW_W        = 15,
    parameter int NUM_DIGITS  = 8,
    parameter bit SIGNED_OUT  = 1,
    parameter bit IN_SIGN_EXT = 0,
    parameter bit BLANK_LZ    = 1
) (
    input logic         CLK,
    input logic         reset,
    io_console_ctrl_if.slave io
);
    localparam int                      BCD_W   = bcd_width(DATA_W);
    localparam longint unsigned         LIM_POS = pow10(NUM_DIGITS);
    localparam longint unsigned         LIM_NEG = pow10(NUM_DIGITS - 1);
    localparam logic [7*NUM_DIGITS-1:0] HEX_RST =
        ({(7*NUM_DIGITS){1'b1}} << 7) | (7*NUM_DIGITS)'(SEG_0);

    logic r_ins_s1, r_ins_s2, r_ins_s3;
    logic [SW_W-1:0] r_sw_s1, r_sw_s2;
    logic w_press;
    logic signed [SW_W-1:0] w_sw_s;
    logic [DATA_W-1:0] w_sw_ext;

    // Button idles high, so the synchroniser resets to 1 to avoid a phantom press
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            r_ins_s1 <= 1'b1;
            r_ins_s2 <= 1'b1;
            r_ins_s3 <= 1'b1;
            r_sw_s1  <= '0;
            r_sw_s2  <= '0;
        end else begin
            r_ins_s1 <= io.insert;
            r_ins_s2 <= r_ins_s1;
            r_ins_s3 <= r_ins_s2;
            r_sw_s1  <= io.SW;
            r_sw_s2  <= r_sw_s1;
        end
    end

    assign w_press  = r_ins_s3 & ~r_ins_s2;
    assign w_sw_s   = r_sw_s2;
    assign w_sw_ext = IN_SIGN_EXT ? DATA_W'(w_sw_s) : DATA_W'(r_sw_s2);

    in_state_t r_in_st, w_in_nx;
    logic w_stall, w_in_cap, r_in_ack;
    logic [DATA_W-1:0] r_user;

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) r_in_st <= IN_IDLE;
        else        r_in_st <= w_in_nx;
    end

    always_comb begin
        w_in_nx = r_in_st;
        if (io.halt) w_in_nx = IN_IDLE;
        else begin
            case (r_in_st)
                IN_IDLE: if (io.in_req)   w_in_nx = IN_WAIT;
                IN_WAIT: if (w_press)     w_in_nx = IN_DONE;
                IN_DONE: if (io.cpu_step) w_in_nx = IN_IDLE;
                default:                  w_in_nx = IN_IDLE;
            endcase
        end
    end

    always_comb begin
        w_stall  = 1'b0;
        w_in_cap = 1'b0;
        case (r_in_st)
            IN_IDLE: w_stall = io.in_req & ~io.halt & reset;
            IN_WAIT: begin
                w_stall  = reset;
                w_in_cap = w_press & ~io.halt;
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            r_user   <= '0;
            r_in_ack <= 1'b0;
        end else begin
            r_in_ack <= w_in_cap;
            if (w_in_cap) r_user <= w_sw_ext;
        end
    end

    cv_state_t r_cv_st, w_cv_nx;
    logic w_out_cap, w_cv_start, w_cv_done, w_b2b_busy;
    logic w_pend_wr, w_pend_clr, w_hex_load, r_pend_vld;
    logic [DATA_W-1:0] r_pend, w_start_mag, r_mag;
    logic signed [DATA_W-1:0] w_start_val;
    logic w_start_neg, r_neg;
    logic [BCD_W-1:0] w_bcd;

    assign w_out_cap = io.cpu_step & io.out_req & ~io.halt;

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) r_cv_st <= CV_IDLE;
        else        r_cv_st <= w_cv_nx;
    end

    always_comb begin
        w_cv_nx = r_cv_st;
        case (r_cv_st)
            CV_IDLE:  if (w_out_cap) w_cv_nx = CV_SHIFT;
            CV_SHIFT: if (w_cv_done) w_cv_nx = CV_DONE;
            CV_DONE:  w_cv_nx = (w_out_cap | r_pend_vld) ? CV_SHIFT : CV_IDLE;
            default:  w_cv_nx = CV_IDLE;
        endcase
    end

    // A capture landing in CV_DONE is newer than the pending value, so it wins
    always_comb begin
        w_cv_start  = 1'b0;
        w_pend_wr   = 1'b0;
        w_pend_clr  = 1'b0;
        w_hex_load  = 1'b0;
        w_start_val = io.cpu_data;
        case (r_cv_st)
            CV_IDLE:  w_cv_start = w_out_cap;
            CV_SHIFT: w_pend_wr  = w_out_cap;
            CV_DONE: begin
                w_hex_load = 1'b1;
                w_pend_clr = 1'b1;
                w_cv_start = w_out_cap | r_pend_vld;
                if (!w_out_cap) w_start_val = r_pend;
            end
            default: ;
        endcase
    end

    assign w_start_neg = SIGNED_OUT & w_start_val[DATA_W-1];
    assign w_start_mag = w_start_neg ? -w_start_val : w_start_val;

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset)          r_pend_vld <= 1'b0;
        else if (w_pend_wr)  r_pend_vld <= 1'b1;
        else if (w_pend_clr) r_pend_vld <= 1'b0;
    end

    always_ff @(posedge CLK) begin
        if (w_pend_wr) r_pend <= io.cpu_data;
        if (w_cv_start) begin
            r_mag <= w_start_mag;
            r_neg <= w_start_neg;
        end
    end

    bin2bcd_seq #(.DATA_W(DATA_W), .BCD_W(BCD_W)) u_bin2bcd (
        .clk     (CLK),
        .rst_n   (reset),
        .i_start (w_cv_start),
        .i_bin   (w_start_mag),
        .o_busy  (w_b2b_busy),
        .o_done  (w_cv_done),
        .o_bcd   (w_bcd)
    );

    logic w_ovf;
    int   w_msd;
    logic [7*NUM_DIGITS-1:0] w_img, r_hex;

    // A negative value also needs one free digit for its sign
    assign w_ovf = (64'(r_mag) >= LIM_POS) | (r_neg & (64'(r_mag) >= LIM_NEG));

    always_comb begin
        w_msd = 0;
        w_img = '1;
        for (int k = 0; k < NUM_DIGITS; k++)
            if (4'(w_bcd >> (4*k)) != 4'd0) w_msd = k;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (w_ovf)
                w_img[7*k +: 7] = (k == 0) ? SEG_E : SEG_BLANK;
            else if (r_neg && (BLANK_LZ ? (k == w_msd + 1) : (k == NUM_DIGITS - 1)))
                w_img[7*k +: 7] = SEG_MINUS;
            else if (!BLANK_LZ || k <= w_msd)
                w_img[7*k +: 7] = seg_of(4'(w_bcd >> (4*k)));
            else
                w_img[7*k +: 7] = SEG_BLANK;
        end
    end

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset)          r_hex <= HEX_RST;
        else if (w_hex_load) r_hex <= w_img;
    end

    assign io.user_input = r_user;
    assign io.stall      = w_stall;
    assign io.in_ack     = r_in_ack;
    assign io.busy       = w_b2b_busy | (r_cv_st == CV_DONE);
    assign io.HEX        = r_hex;
endmodule

// File: doc/io_console_ctrl.md
Name: io_console_ctrl

Overview:
Parametrised console I/O controller serving the processor's IN/OUT instructions. It generalises the fixed 8-digit, 15-switch I/O block in three ways: configurable data/switch/digit widths, a sequential binary-to-BCD display path with signed and overflow handling, and a stall/acknowledge handshake with a synchronised, edge-detected insert button. It sits beside the register file: `ReadData1` feeds `cpu_data`, and `user_input` feeds the write-back mux.

Parameters:
DATA_W, 32, processor data width.
SW_W, 15, switch bank width; must be ≤ DATA_W.
NUM_DIGITS, 8, seven-segment digits driven; range 1..10.
SIGNED_OUT, 1, 1 = OUT value is two's complement and shows '-' when negative.
IN_SIGN_EXT, 0, 1 = sign-extend switches into `user_input`; 0 = zero-extend.
BLANK_LZ, 1, 1 = blank leading zeros (digit 0 always lit).

Ports:
CLK  in  1  system clock, sole clock.
reset  in  1  asynchronous, active-low reset.
cpu_step  in  1  one-CLK pulse marking the processor instruction boundary.
in_req  in  1  current instruction is IN (input_flag).
out_req  in  1  current instruction is OUT (output_flag).
halt  in  1  processor halted.
cpu_data  in  DATA_W  value to display (ReadData1).
SW  in  SW_W  raw switches.
insert  in  1  raw pushbutton, active-low (pressed = 0).
user_input  out  DATA_W  captured switch value.
stall  out  1  processor must hold its state.
in_ack  out  1  one-CLK pulse when `user_input` is updated.
busy  out  1  BCD conversion in progress.
HEX  out  7*NUM_DIGITS  segments, active-low; digit k at [7k+6:7k].

Behaviour:
Reset (reset = 0, asynchronous):
- `user_input` = 0; `stall`, `in_ack`, `busy` = 0.
- All digits blank (7'h7F) except digit 0, which shows '0' (7'h40).
- FSMs idle; `pending` flag cleared.

Insert path:
- 2-FF synchroniser on `insert`, then falling-edge detect, giving `press` (1 CLK).
- `SW` is also 2-FF synchronised.

Input FSM (IN_IDLE, IN_WAIT, IN_DONE):
- IN_IDLE → IN_WAIT when `in_req` = 1 and `halt` = 0. `stall` is combinational: 1 in IN_WAIT, and 1 in IN_IDLE while `in_req` & !`halt`.
- IN_WAIT: on `press`, capture the extended SW into `user_input`, pulse `in_ack`, go to IN_DONE. `stall` = 0 from the next cycle.
- IN_DONE → IN_IDLE on `cpu_step`. This prevents one press from satisfying two IN instructions and allows back-to-back INs.
- `halt` = 1 in any state → IN_IDLE, `stall` = 0, `user_input` kept.
- A press outside IN_WAIT is ignored.

Output capture:
- On a cycle where `cpu_step` & `out_req` & !`halt`, latch `cpu_data`.
- If the converter is idle, start it. If busy, store into a 1-deep pending register; last write wins.

Converter FSM (CV_IDLE, CV_SHIFT, CV_DONE):
- CV_SHIFT: double-dabble over |value|, one bit per cycle for DATA_W cycles.
- For SIGNED_OUT with value = most-negative, take the magnitude as unsigned DATA_W bits (2^(DATA_W-1)).
- CV_DONE (1 cycle): compute the display image and load HEX atomically. Then restart from pending if set, else go to CV_IDLE.
- Latency from the capture cycle to HEX update is DATA_W+2 CLK.
- HEX holds its old image throughout a conversion.
- `busy` = 1 in CV_SHIFT and CV_DONE.

Display image:
- Segment encoding, gfedcba active-low: 0 = 40, 1 = 79, 2 = 24, 3 = 30, 4 = 19, 5 = 12, 6 = 02, 7 = 78, 8 = 00, 9 = 10, '-' = 3F, 'E' = 06, blank = 7F.
- Negative value: '-' in the digit directly left of the most significant nonzero digit. With BLANK_LZ = 0, '-' goes in the top digit.
- Overflow: |value| ≥ 10^NUM_DIGITS, or a negative value needing all NUM_DIGITS digits. Display digit 0 = 'E', all others blank.
- No wrap: values never silently truncate.

Decomposition:
- Package `io_console_pkg`: segment constants (SEG_0..SEG_9, SEG_MINUS, SEG_E, SEG_BLANK) and state enums for both FSMs.
- Package functions: `pow10(n)` for the overflow limit and `bcd_width` for the conversion register.
- One sub-module, `bin2bcd_seq`: start/busy/done handshake, width-parametrised, owns CV_SHIFT.
- Synchroniser, FSMs and display mapping stay in the top.

Test Plan:
- Reset release, then OUT 1234 with cpu_step (NUM_DIGITS = 8). HEX unchanged for 33 CLK, then at 34: d0 = 19, d1 = 30, d2 = 24, d3 = 79, d4..d7 = 7F; `busy` high for 33 cycles.
- OUT -5 (SIGNED_OUT = 1): d0 = 12, d1 = 3F, rest 7F. Then OUT 32'h80000000: d0 = 06, rest 7F (overflow).
- IN with SW = 15'h7FFF: `stall` = 1 until the debounced press edge; `user_input` = 32'h00007FFF and `in_ack` for 1 CLK. With IN_SIGN_EXT = 1: 32'hFFFFFFFF.
- Two consecutive IN instructions: a single press yields one `in_ack` only. `stall` re-asserts after `cpu_step` and needs a second press; a press during IN_DONE is ignored.
- Three OUTs (7, 8, 9) while busy: display shows 7, then 9; 8 is never shown.
- Mid-operation events:
  - `halt` during IN_WAIT: `stall` drops the next cycle.
  - reset low mid-conversion: outputs immediately at reset values; `busy` = 0.
